// File: rtl/zap_wb_merger_pkg.sv
// Wishbone cycle-type constants and the request bundle that the merger registers
// onto the external bus.
package zap_wb_merger_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_BURST   = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    typedef struct packed {
        logic        stb;
        logic        cyc;
        logic        wen;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic [31:0] adr;
        logic [2:0]  cti;
    } wb_req_t;

    // Quiet bus: no strobe, no cycle, classic cycle type.
    function automatic wb_req_t wb_idle();
        wb_req_t r;
        r     = '0;
        r.cti = CTI_CLASSIC;
        return r;
    endfunction

endpackage

// File: rtl/zap_wb_merger_if.sv
// Bus bundle between the code/data caches, the merger and the external Wishbone slave.
interface zap_wb_merger_if;

    logic        i_c_wb_stb;
    logic        i_c_wb_cyc;
    logic        i_c_wb_wen;
    logic [3:0]  i_c_wb_sel;
    logic [31:0] i_c_wb_dat;
    logic [31:0] i_c_wb_adr;
    logic [2:0]  i_c_wb_cti;
    logic        o_c_wb_ack;

    logic        i_d_wb_stb;
    logic        i_d_wb_cyc;
    logic        i_d_wb_wen;
    logic [3:0]  i_d_wb_sel;
    logic [31:0] i_d_wb_dat;
    logic [31:0] i_d_wb_adr;
    logic [2:0]  i_d_wb_cti;
    logic        o_d_wb_ack;

    logic        o_wb_stb;
    logic        o_wb_cyc;
    logic        o_wb_wen;
    logic [3:0]  o_wb_sel;
    logic [31:0] o_wb_dat;
    logic [31:0] o_wb_adr;
    logic [2:0]  o_wb_cti;
    logic        i_wb_ack;
    logic [31:0] i_wb_dat;
    logic [31:0] o_wb_dat_rd;

    // The merger's own view.
    modport slave (
        input  i_c_wb_stb, i_c_wb_cyc, i_c_wb_wen, i_c_wb_sel, i_c_wb_dat, i_c_wb_adr, i_c_wb_cti,
        output o_c_wb_ack,
        input  i_d_wb_stb, i_d_wb_cyc, i_d_wb_wen, i_d_wb_sel, i_d_wb_dat, i_d_wb_adr, i_d_wb_cti,
        output o_d_wb_ack,
        output o_wb_stb, o_wb_cyc, o_wb_wen, o_wb_sel, o_wb_dat, o_wb_adr, o_wb_cti,
        input  i_wb_ack, i_wb_dat,
        output o_wb_dat_rd
    );

    // The surrounding caches and external slave.
    modport master (
        output i_c_wb_stb, i_c_wb_cyc, i_c_wb_wen, i_c_wb_sel, i_c_wb_dat, i_c_wb_adr, i_c_wb_cti,
        input  o_c_wb_ack,
        output i_d_wb_stb, i_d_wb_cyc, i_d_wb_wen, i_d_wb_sel, i_d_wb_dat, i_d_wb_adr, i_d_wb_cti,
        input  o_d_wb_ack,
        input  o_wb_stb, o_wb_cyc, o_wb_wen, o_wb_sel, o_wb_dat, o_wb_adr, o_wb_cti,
        output i_wb_ack, i_wb_dat,
        input  o_wb_dat_rd
    );

endinterface

// File: rtl/zap_wb_merger.sv
// Two-master Wishbone arbiter: grants the code or data cache and registers the
// winner's next-cycle signals onto the single external bus.
module zap_wb_merger
    import zap_wb_merger_pkg::*;
#(
    parameter bit DATA_PRIORITY = 1'b1
)(
    input logic            i_clk,
    input logic            i_reset,
    zap_wb_merger_if.slave bus
);

    typedef enum logic { SEL_CODE = 1'b0, SEL_DATA = 1'b1 } sel_e;

    sel_e    state_q, state_d;
    wb_req_t wb_q, wb_d;
    wb_req_t c_req, d_req;
    logic    switch_pt;
    logic    own_cyc;
    logic    peer_cyc;

    assign c_req = '{stb: bus.i_c_wb_stb, cyc: bus.i_c_wb_cyc, wen: bus.i_c_wb_wen,
                     sel: bus.i_c_wb_sel, dat: bus.i_c_wb_dat, adr: bus.i_c_wb_adr,
                     cti: bus.i_c_wb_cti};
    assign d_req = '{stb: bus.i_d_wb_stb, cyc: bus.i_d_wb_cyc, wen: bus.i_d_wb_wen,
                     sel: bus.i_d_wb_sel, dat: bus.i_d_wb_dat, adr: bus.i_d_wb_adr,
                     cti: bus.i_d_wb_cti};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= SEL_CODE;
            wb_q    <= wb_idle();
        end else begin
            state_q <= state_d;
            wb_q    <= wb_d;
        end
    end

    // Grant may only move when the bus is free or the current beat is being acknowledged;
    // a master holding cyc keeps the grant, which keeps bursts intact.
    always_comb begin
        state_d   = state_q;
        switch_pt = !wb_q.stb || (wb_q.stb && bus.i_wb_ack);
        own_cyc   = (state_q == SEL_DATA) ? d_req.cyc : c_req.cyc;
        peer_cyc  = (state_q == SEL_DATA) ? c_req.cyc : d_req.cyc;
        if (switch_pt) begin
            if (c_req.cyc && d_req.cyc && !wb_q.cyc) begin
                state_d = DATA_PRIORITY ? SEL_DATA : SEL_CODE;
            end else if (!own_cyc && peer_cyc) begin
                state_d = (state_q == SEL_DATA) ? SEL_CODE : SEL_DATA;
            end
        end
    end

    // ACK follows the grant that owns the beat on the bus, not the upcoming one.
    always_comb begin
        wb_d           = (state_d == SEL_DATA) ? d_req : c_req;
        bus.o_c_wb_ack = bus.i_wb_ack && (state_q == SEL_CODE);
        bus.o_d_wb_ack = bus.i_wb_ack && (state_q == SEL_DATA);
    end

    assign bus.o_wb_stb    = wb_q.stb;
    assign bus.o_wb_cyc    = wb_q.cyc;
    assign bus.o_wb_wen    = wb_q.wen;
    assign bus.o_wb_sel    = wb_q.sel;
    assign bus.o_wb_dat    = wb_q.dat;
    assign bus.o_wb_adr    = wb_q.adr;
    assign bus.o_wb_cti    = wb_q.cti;
    assign bus.o_wb_dat_rd = bus.i_wb_dat;

endmodule

// File: tb/tb_zap_wb_merger.sv
// Randomized self-checking bench for zap_wb_merger: two queue-driven cache masters,
// a random-wait slave, and a cycle-level reference model of the arbitration rules.
module tb_zap_wb_merger;
    import zap_wb_merger_pkg::*;

    localparam bit DATA_PRIO = 1'b1;

    typedef struct packed {
        logic        wen;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic [31:0] adr;
        logic [2:0]  cti;
    } xact_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    zap_wb_merger_if bus ();

    zap_wb_merger #(.DATA_PRIORITY(DATA_PRIO)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    xact_t       cq[$];
    xact_t       dq[$];
    int          doneOrder[$];
    bit          gap[2];
    int          waitCnt[2];
    int          ackCnt[2];
    int          doneCnt[2];
    int          slvWait = -1;
    int          forceWait = -1;
    bit          forceAck = 1'b0;
    bit          randomPhase = 1'b0;
    logic        ackNow;
    logic [31:0] rdData;
    int          mOwner = 0;
    wb_req_t     mOut;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int qSize(input int m);
        return (m == 0) ? cq.size() : dq.size();
    endfunction

    function automatic void pushXact(input int m, input xact_t x);
        if (m == 0) cq.push_back(x);
        else        dq.push_back(x);
    endfunction

    function automatic xact_t single(input logic wen, input logic [3:0] sel,
                                     input logic [31:0] dat, input logic [31:0] adr);
        xact_t x;
        x.wen = wen;
        x.sel = sel;
        x.dat = dat;
        x.adr = adr;
        x.cti = CTI_CLASSIC;
        return x;
    endfunction

    function automatic void pushBurst(input int m, input logic [31:0] base);
        xact_t x;
        for (int i = 0; i < 4; i++) begin
            x.wen = 1'b0;
            x.sel = 4'hF;
            x.dat = $urandom;
            x.adr = base + 32'(4 * i);
            x.cti = (i == 3) ? CTI_EOB : CTI_BURST;
            pushXact(m, x);
        end
    endfunction

    // Master m's next-cycle drive: head of its queue, or idle with junk payload.
    function automatic wb_req_t reqFor(input int m);
        wb_req_t r;
        xact_t   h;
        if (!gap[m] && qSize(m) > 0) begin
            h = (m == 0) ? cq[0] : dq[0];
            r = {2'b11, h};
        end else begin
            r.stb = 1'b0;
            r.cyc = 1'b0;
            r.wen = 1'($urandom);
            r.sel = 4'($urandom);
            r.dat = $urandom;
            r.adr = $urandom;
            r.cti = 3'($urandom);
        end
        return r;
    endfunction

    task automatic setMaster(input wb_req_t c, input wb_req_t d);
        bus.i_c_wb_stb = c.stb;
        bus.i_c_wb_cyc = c.cyc;
        bus.i_c_wb_wen = c.wen;
        bus.i_c_wb_sel = c.sel;
        bus.i_c_wb_dat = c.dat;
        bus.i_c_wb_adr = c.adr;
        bus.i_c_wb_cti = c.cti;
        bus.i_d_wb_stb = d.stb;
        bus.i_d_wb_cyc = d.cyc;
        bus.i_d_wb_wen = d.wen;
        bus.i_d_wb_sel = d.sel;
        bus.i_d_wb_dat = d.dat;
        bus.i_d_wb_adr = d.adr;
        bus.i_d_wb_cti = d.cti;
    endtask

    // A master that sees its ACK retires the head beat and pairs it with the bus contents.
    task automatic masterAck(input int m);
        xact_t h;
        ackCnt[m]++;
        checkOutput("ack_has_request", 128'(qSize(m) > 0), 128'(1));
        if (qSize(m) == 0) return;
        if (m == 0) h = cq.pop_front();
        else        h = dq.pop_front();
        checkOutput("ack_pairs_xact",
                    128'({bus.o_wb_stb, bus.o_wb_cyc, bus.o_wb_wen, bus.o_wb_sel,
                          bus.o_wb_dat, bus.o_wb_adr, bus.o_wb_cti}),
                    128'({2'b11, h}));
        if (h.cti != CTI_BURST) begin
            gap[m] = 1'b1;
            doneOrder.push_back(m);
            doneCnt[m]++;
            checkOutput("fair_wait", 128'(waitCnt[m] <= 1), 128'(1));
            waitCnt[m] = 0;
            if (qSize(1 - m) > 0) waitCnt[1 - m]++;
        end
    endtask

    task automatic applyStimulus(input bit doReset);
        wb_req_t cDrv;
        wb_req_t dDrv;
        @(negedge clk);
        rst    = doReset;
        ackNow = 1'b0;
        if (doReset) begin
            slvWait = -1;
        end else if (forceAck) begin
            ackNow = 1'b1;
        end else if (bus.o_wb_stb) begin
            if (slvWait < 0) slvWait = (forceWait >= 0) ? forceWait : int'($urandom_range(0, 3));
            if (slvWait == 0) begin
                ackNow  = 1'b1;
                slvWait = -1;
            end else begin
                slvWait--;
            end
        end else begin
            slvWait = -1;
        end
        rdData       = $urandom;
        bus.i_wb_ack = ackNow;
        bus.i_wb_dat = rdData;
        #1;
        checkOutput("code_ack", 128'(bus.o_c_wb_ack), 128'(ackNow && mOwner == 0));
        checkOutput("data_ack", 128'(bus.o_d_wb_ack), 128'(ackNow && mOwner == 1));
        checkOutput("rd_broadcast", 128'(bus.o_wb_dat_rd), 128'(rdData));
        if (doReset) begin
            cq.delete();
            dq.delete();
            gap[0] = 1'b0;
            gap[1] = 1'b0;
            waitCnt[0] = 0;
            waitCnt[1] = 0;
        end else if (!forceAck) begin
            if (bus.o_c_wb_ack) masterAck(0);
            if (bus.o_d_wb_ack) masterAck(1);
        end
        if (randomPhase) begin
            for (int m = 0; m < 2; m++) begin
                if (qSize(m) == 0 && $urandom_range(0, 2) == 0) begin
                    if ($urandom_range(0, 3) == 0) pushBurst(m, $urandom & 32'hFFFF_FFF0);
                    else pushXact(m, single(1'($urandom), 4'($urandom), $urandom, $urandom));
                end
            end
        end
        cDrv = reqFor(0);
        dDrv = reqFor(1);
        setMaster(cDrv, dDrv);
        // Reference: owner may change only when the bus is free or the beat completes.
        if (doReset) begin
            mOwner = 0;
            mOut   = wb_idle();
        end else begin
            if (!mOut.stb || ackNow) begin
                if (cDrv.cyc && dDrv.cyc && !mOut.cyc) mOwner = DATA_PRIO ? 1 : 0;
                else if (mOwner == 0 && !cDrv.cyc && dDrv.cyc) mOwner = 1;
                else if (mOwner == 1 && !dDrv.cyc && cDrv.cyc) mOwner = 0;
            end
            mOut = (mOwner == 1) ? dDrv : cDrv;
        end
        @(posedge clk);
        #1;
        checkOutput("wb_out",
                    128'({bus.o_wb_stb, bus.o_wb_cyc, bus.o_wb_wen, bus.o_wb_sel,
                          bus.o_wb_dat, bus.o_wb_adr, bus.o_wb_cti}),
                    128'(mOut));
        gap[0] = 1'b0;
        gap[1] = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((cq.size() != 0 || dq.size() != 0 || bus.o_wb_stb) && n < 200) begin
            applyStimulus(1'b0);
            n++;
        end
        checkOutput("idle_timeout", 128'(n < 200), 128'(1));
    endtask

    task automatic startTest();
        doneOrder.delete();
        ackCnt[0] = 0;
        ackCnt[1] = 0;
    endtask

    initial begin
        setMaster(wb_idle(), wb_idle());
        bus.i_wb_ack = 1'b0;
        bus.i_wb_dat = '0;
        repeat (3) applyStimulus(1'b1);
        checkOutput("reset_cti", 128'(bus.o_wb_cti), 128'(CTI_CLASSIC));
        checkOutput("reset_cyc", 128'(bus.o_wb_cyc), 128'(0));

        // Lone data read.
        startTest();
        pushXact(1, single(1'b0, 4'hF, 32'h0, 32'h100));
        applyStimulus(1'b0);
        checkOutput("data_adr_0x100", 128'(bus.o_wb_adr), 128'(32'h100));
        waitIdle();
        checkOutput("read_code_acks", 128'(ackCnt[0]), 128'(0));
        checkOutput("read_data_acks", 128'(ackCnt[1]), 128'(1));

        // Simultaneous first requests.
        startTest();
        pushXact(0, single(1'b0, 4'hF, 32'h0, 32'h180));
        pushXact(1, single(1'b0, 4'hF, 32'h0, 32'h1C0));
        waitIdle();
        checkOutput("tie_count", 128'(doneOrder.size()), 128'(2));
        if (doneOrder.size() >= 2) begin
            checkOutput("tie_first_data", 128'(doneOrder[0]), 128'(1));
            checkOutput("tie_then_code", 128'(doneOrder[1]), 128'(0));
        end

        // Code burst with data arriving mid-burst.
        startTest();
        pushBurst(0, 32'h200);
        repeat (2) applyStimulus(1'b0);
        pushXact(1, single(1'b0, 4'hF, 32'h0, 32'h300));
        waitIdle();
        checkOutput("burst_code_acks", 128'(ackCnt[0]), 128'(4));
        checkOutput("burst_data_acks", 128'(ackCnt[1]), 128'(1));
        if (doneOrder.size() >= 2) begin
            checkOutput("burst_first_code", 128'(doneOrder[0]), 128'(0));
            checkOutput("burst_then_data", 128'(doneOrder[1]), 128'(1));
        end

        // Write held through wait states.
        startTest();
        forceWait = 2;
        pushXact(0, single(1'b1, 4'b0011, 32'hDEADBEEF, 32'h400));
        waitIdle();
        forceWait = -1;
        checkOutput("write_code_acks", 128'(ackCnt[0]), 128'(1));
        checkOutput("write_data_acks", 128'(ackCnt[1]), 128'(0));

        // Reset in the middle of a data burst, then a stray ACK on the idle bus.
        startTest();
        pushBurst(1, 32'h500);
        repeat (3) applyStimulus(1'b0);
        applyStimulus(1'b1);
        checkOutput("midreset_cyc", 128'(bus.o_wb_cyc), 128'(0));
        checkOutput("midreset_cti", 128'(bus.o_wb_cti), 128'(CTI_CLASSIC));
        forceAck = 1'b1;
        applyStimulus(1'b0);
        forceAck = 1'b0;
        checkOutput("stray_ack_data", 128'(bus.o_d_wb_ack), 128'(0));

        // Random traffic from both masters.
        startTest();
        doneCnt[0] = 0;
        doneCnt[1] = 0;
        randomPhase = 1'b1;
        repeat (1000) applyStimulus(1'b0);
        randomPhase = 1'b0;
        waitIdle();
        checkOutput("random_code_served", 128'(doneCnt[0] > 0), 128'(1));
        checkOutput("random_data_served", 128'(doneCnt[1] > 0), 128'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
